// File: rtl/md5_dispatch_pkg.sv
// Shared types and BCD helpers for the MD5 chunk dispatcher.
// bcd_inc_at is also usable by other BCD counters (e.g. the ms timer).
package md5_dispatch_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam int unsigned PASS_DIGITS = 8;

  // Lower `digits` BCD digits set to 9, the rest 0.
  function automatic logic [31:0] nines_mask(input int unsigned digits);
    logic [31:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < PASS_DIGITS; i++) begin
      if (i < digits) mask[4*i +: 4] = 4'h9;
    end
    return mask;
  endfunction

  // Increment BCD digit `pos` with upward carry; bit 32 is the carry out of the top digit.
  function automatic logic [32:0] bcd_inc_at(input logic [31:0] val, input int unsigned pos);
    logic [31:0] res;
    logic        carry;
    logic [3:0]  d;
    res   = val;
    carry = 1'b0;
    for (int unsigned i = 0; i < PASS_DIGITS; i++) begin
      d = val[4*i +: 4];
      if (i == pos) carry = 1'b1;
      if (carry) begin
        if (d == 4'd9) begin
          d = 4'd0;
        end else begin
          d     = d + 4'd1;
          carry = 1'b0;
        end
      end
      res[4*i +: 4] = d;
    end
    return {carry, res};
  endfunction

endpackage

// File: rtl/md5_dispatch_if.sv
// Dispatcher <-> brute-force core pool bus.
interface md5_dispatch_if #(
  parameter int unsigned NUM_CORES = 4
);
  logic [127:0]            core_hash;
  logic [NUM_CORES-1:0]    core_start;
  logic [32*NUM_CORES-1:0] core_low;
  logic [32*NUM_CORES-1:0] core_high;
  logic                    core_abort;
  logic [NUM_CORES-1:0]    core_done;
  logic [NUM_CORES-1:0]    core_found;
  logic [32*NUM_CORES-1:0] core_pass;

  modport master (
    output core_hash, core_start, core_low, core_high, core_abort,
    input  core_done, core_found, core_pass
  );

  modport slave (
    input  core_hash, core_start, core_low, core_high, core_abort,
    output core_done, core_found, core_pass
  );
endinterface

// File: rtl/md5_chunk_ptr.sv
// Chunk pointer: next chunk start in BCD, its all-nines end, and the exhausted flag.
module md5_chunk_ptr
  import md5_dispatch_pkg::*;
#(
  parameter int unsigned CHUNK_DIGITS = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        advance_i,
  output logic [31:0] low_o,
  output logic [31:0] high_o,
  output logic        exhausted_o
);

  logic [31:0] low_q, low_d;
  logic        exh_q, exh_d;
  logic [32:0] inc;

  // clear_i presents a zeroed pointer in the same cycle so the start edge can dispatch chunk 0.
  always_comb begin
    low_o       = clear_i ? '0 : low_q;
    exhausted_o = clear_i ? 1'b0 : exh_q;
    high_o      = low_o | nines_mask(CHUNK_DIGITS);
    inc         = bcd_inc_at(low_o, CHUNK_DIGITS);
    low_d       = low_o;
    exh_d       = exhausted_o;
    if (advance_i && !exhausted_o) begin
      if (inc[32]) exh_d = 1'b1;
      else         low_d = inc[31:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      low_q <= '0;
      exh_q <= 1'b0;
    end else begin
      low_q <= low_d;
      exh_q <= exh_d;
    end
  end

endmodule

// File: rtl/md5_dispatch.sv
// Chunk scheduler: hands BCD password chunks to idle md5_bf cores, collects results,
// aborts all cores on the first match.
module md5_dispatch
  import md5_dispatch_pkg::*;
#(
  parameter int unsigned NUM_CORES    = 4,
  parameter int unsigned CHUNK_DIGITS = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] hash,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [31:0]  pass,
  output logic [15:0]  chunks_issued,
  md5_dispatch_if.master cif
);

  state_e                          state_q, state_d;
  logic [127:0]                    hash_q, hash_d;
  logic                            found_q, found_d;
  logic [31:0]                     pass_q, pass_d;
  logic [15:0]                     chunks_q, chunks_d;
  logic [NUM_CORES-1:0]            busy_q, busy_d;
  logic [NUM_CORES-1:0]            start_q, start_d;
  logic                            abort_q, abort_d;
  logic [NUM_CORES-1:0][31:0]      low_q, low_d, high_q, high_d;

  logic                 accept, any_found, fire;
  logic [NUM_CORES-1:0] remaining, cand, grant;
  logic [31:0]          ptr_low, ptr_high;
  logic                 ptr_exh;

  md5_chunk_ptr #(
    .CHUNK_DIGITS (CHUNK_DIGITS)
  ) u_chunk_ptr (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (accept),
    .advance_i   (fire),
    .low_o       (ptr_low),
    .high_o      (ptr_high),
    .exhausted_o (ptr_exh)
  );

  always_comb begin
    accept    = start && (state_q == S_IDLE || state_q == S_DONE);
    any_found = (|cif.core_found) && (state_q == S_RUN || state_q == S_DRAIN);
    remaining = busy_q & ~cif.core_done;

    state_d  = state_q;
    hash_d   = hash_q;
    found_d  = found_q;
    pass_d   = pass_q;
    chunks_d = chunks_q;
    busy_d   = accept ? '0 : remaining;
    start_d  = '0;
    abort_d  = 1'b0;
    low_d    = low_q;
    high_d   = high_q;

    // The accepting edge also dispatches chunk 0 to core 0 (all cores idle after start).
    fire  = accept || (state_q == S_RUN && !any_found && !ptr_exh);
    cand  = accept ? '1 : (~busy_q & ~cif.core_done);
    grant = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (cand[i] && grant == '0) grant[i] = 1'b1;
    end
    if (grant == '0) fire = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_RUN;
          hash_d  = hash;
          found_d = 1'b0;
          pass_d  = '0;
        end
      end
      S_RUN: begin
        if (!any_found && ptr_exh) state_d = (remaining == '0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (!any_found && remaining == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (any_found) begin
      state_d = S_DONE;
      found_d = 1'b1;
      abort_d = 1'b1;
      busy_d  = '0;
      for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
        if (cif.core_found[i]) pass_d = cif.core_pass[32*i +: 32];
      end
    end

    if (fire) begin
      start_d  = grant;
      busy_d   = busy_d | grant;
      chunks_d = (accept ? 16'd0 : chunks_q) + 16'd1;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (grant[i]) begin
          low_d[i]  = ptr_low;
          high_d[i] = ptr_high;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      hash_q   <= '0;
      found_q  <= 1'b0;
      pass_q   <= '0;
      chunks_q <= '0;
      busy_q   <= '0;
      start_q  <= '0;
      abort_q  <= 1'b0;
      low_q    <= '0;
      high_q   <= '0;
    end else begin
      state_q  <= state_d;
      hash_q   <= hash_d;
      found_q  <= found_d;
      pass_q   <= pass_d;
      chunks_q <= chunks_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      low_q    <= low_d;
      high_q   <= high_d;
    end
  end

  assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign found          = found_q;
  assign pass           = pass_q;
  assign chunks_issued  = chunks_q;
  assign cif.core_hash  = hash_q;
  assign cif.core_start = start_q;
  assign cif.core_low   = low_q;
  assign cif.core_high  = high_q;
  assign cif.core_abort = abort_q;

endmodule

// File: tb/tb_md5_dispatch.sv
// Directed bench for md5_dispatch with behavioural cores of programmable latency and a
// scoreboard of expected chunk ranges.
module tb_md5_dispatch;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [127:0] hash;
  logic         busy, done, found;
  logic [31:0]  pass;
  logic [15:0]  chunks_issued;

  md5_dispatch_if #(.NUM_CORES(2)) cif ();

  md5_dispatch #(
    .NUM_CORES    (2),
    .CHUNK_DIGITS (6)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .hash          (hash),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .pass          (pass),
    .chunks_issued (chunks_issued),
    .cif           (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total, bad, cyc;
  int          found_step, last_done_step, ndisp;
  logic [1:0]  active, mbusy, pend, inj_found;
  int          cnt [2];
  int          lat [2];
  logic [31:0] mlo [2];
  logic [31:0] inj_pass [2];
  logic [31:0] target, last_lo, last_hi;
  bit          target_en;
  exp_t        expq[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core models: sample DUT at negedge, drive core responses for the next posedge.
  task automatic model();
    logic [1:0] st;
    int         ec;
    exp_t       e;
    st = cif.core_start;
    if (cyc == found_step + 1) begin
      chk("abort_pulse", cif.core_abort, 1'b1);
      chk("done_found", {done, found}, 2'b11);
      chk("no_start_with_abort", st, 2'b00);
    end
    if (cyc == found_step + 2) chk("abort_once", cif.core_abort, 1'b0);
    cif.core_done  = '0;
    cif.core_found = '0;
    cif.core_pass  = '0;
    if (cif.core_abort) begin
      active = '0;
      mbusy  = '0;
      pend   = '0;
    end
    if (st != 2'b00) begin
      ec = 2;
      for (int i = 1; i >= 0; i--) if (!mbusy[i]) ec = i;
      chk("start_core", st, (ec < 2) ? (2'b01 << ec) : 2'b00);
      for (int i = 0; i < 2; i++) begin
        if (st[i]) begin
          if (expq.size() == 0) begin
            chk("sb_underflow", st[i], 1'b0);
          end else begin
            e = expq.pop_front();
            chk("core_low", cif.core_low[32*i +: 32], e.lo);
            chk("core_high", cif.core_high[32*i +: 32], e.hi);
          end
          active[i] = 1'b1;
          mbusy[i]  = 1'b1;
          cnt[i]    = lat[i];
          mlo[i]    = cif.core_low[32*i +: 32];
          last_lo   = cif.core_low[32*i +: 32];
          last_hi   = cif.core_high[32*i +: 32];
          ndisp++;
        end
      end
    end
    // A core finishing now is still seen busy by the dispatch one cycle later.
    mbusy = mbusy & ~pend;
    pend  = '0;
    for (int i = 0; i < 2; i++) begin
      if (inj_found[i]) begin
        inj_found[i]          = 1'b0;
        cif.core_found[i]     = 1'b1;
        cif.core_done[i]      = 1'b1;
        cif.core_pass[32*i +: 32] = inj_pass[i];
        active[i]             = 1'b0;
        pend[i]               = 1'b1;
        found_step            = cyc;
      end else if (active[i] && !st[i]) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          active[i]        = 1'b0;
          pend[i]          = 1'b1;
          cif.core_done[i] = 1'b1;
          last_done_step   = cyc;
          if (target_en && target >= mlo[i] && target <= (mlo[i] | 32'h00999999)) begin
            cif.core_found[i]         = 1'b1;
            cif.core_pass[32*i +: 32] = target;
            found_step                = cyc;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    model();
  endtask

  task automatic model_reset();
    active = '0; mbusy = '0; pend = '0; inj_found = '0;
    ndisp = 0; found_step = -10; last_done_step = -10;
    expq.delete();
  endtask

  task automatic do_start(input logic [127:0] h);
    exp_t e;
    model_reset();
    for (int k = 0; k < 100; k++) begin
      e.lo = {4'(k / 10), 4'(k % 10), 24'h0};
      e.hi = e.lo | 32'h00999999;
      expq.push_back(e);
    end
    start = 1'b1;
    hash  = h;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int limit, output int t);
    t = -1;
    for (int n = 0; n < limit; n++) begin
      step();
      if (done === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("timeout_done", done, 1'b1);
  endtask

  initial begin
    int t;
    total = 0; bad = 0; cyc = 0;
    target = '0; target_en = 0; last_lo = '0; last_hi = '0;
    lat[0] = 3; lat[1] = 5; inj_pass[0] = '0; inj_pass[1] = '0;
    model_reset();
    reset_n = 1'b0; start = 1'b0; hash = '0;
    cif.core_done = '0; cif.core_found = '0; cif.core_pass = '0;
    repeat (3) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_found", found, 1'b0);
    chk("rst_pass", pass, 32'h0);
    chk("rst_chunks", chunks_issued, 16'h0);
    chk("rst_core_start", cif.core_start, 2'b00);
    chk("rst_core_abort", cif.core_abort, 1'b0);
    chk("rst_core_hash", cif.core_hash, 128'h0);
    chk("rst_core_low", cif.core_low, 64'h0);
    chk("rst_core_high", cif.core_high, 64'h0);
    reset_n = 1'b1;
    repeat (2) step();
    chk("idle_no_dispatch", cif.core_start, 2'b00);

    // Match in chunk 07.
    target = 32'h07654231; target_en = 1; lat[0] = 3; lat[1] = 5;
    do_start(128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
    chk("first_start_core0", cif.core_start, 2'b01);
    chk("first_low", cif.core_low[31:0], 32'h0);
    chk("core_hash", cif.core_hash, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
    run_until_done(2000, t);
    chk("t1_found", found, 1'b1);
    chk("t1_pass", pass, 32'h07654231);
    chk("t1_chunks", chunks_issued, 16'(ndisp));
    chk("t1_busy", busy, 1'b0);
    repeat (2) step();

    // Exhaustion; latencies make both cores finish in the same cycle.
    target_en = 0; lat[0] = 4; lat[1] = 3;
    do_start(128'h1);
    run_until_done(2000, t);
    chk("t2_done_latency", t, last_done_step + 1);
    chk("t2_found", found, 1'b0);
    chk("t2_chunks", chunks_issued, 16'd100);
    chk("t2_last_low", last_lo, 32'h99000000);
    chk("t2_last_high", last_hi, 32'h99999999);
    chk("t2_sb_left", expq.size(), 0);
    repeat (2) step();

    // Start ignored while busy, then simultaneous found on both cores.
    lat[0] = 50; lat[1] = 50;
    do_start(128'hBEEF);
    repeat (3) step();
    chk("t3_chunks", chunks_issued, 16'd2);
    start = 1'b1; hash = 128'hDEAD;
    step();
    start = 1'b0;
    step();
    chk("t3_hash_kept", cif.core_hash, 128'hBEEF);
    chk("t3_chunks_kept", chunks_issued, 16'd2);
    chk("t3_low1_kept", cif.core_low[63:32], 32'h01000000);
    chk("t3_busy", busy, 1'b1);
    inj_pass[0] = 32'h11111111; inj_pass[1] = 32'h22222222; inj_found = 2'b11;
    step();
    step();
    chk("t3_pass_lowest", pass, 32'h11111111);
    chk("t3_found", found, 1'b1);
    step();

    // Restart from S_DONE.
    lat[0] = 2; lat[1] = 3;
    do_start(128'hC0FFEE);
    chk("t4_restart_core0", cif.core_start, 2'b01);
    chk("t4_restart_low", cif.core_low[31:0], 32'h0);
    chk("t4_restart_high", cif.core_high[31:0], 32'h00999999);
    chk("t4_restart_chunks", chunks_issued, 16'd1);
    chk("t4_restart_done", {done, found}, 2'b00);
    chk("t4_restart_hash", cif.core_hash, 128'hC0FFEE);
    repeat (10) step();

    // Reset mid-search.
    reset_n = 1'b0;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_found", found, 1'b0);
    chk("t5_core_start", cif.core_start, 2'b00);
    chk("t5_core_abort", cif.core_abort, 1'b0);
    chk("t5_core_low", cif.core_low, 64'h0);
    chk("t5_chunks", chunks_issued, 16'h0);
    step();
    reset_n = 1'b1;
    model_reset();
    for (int n = 0; n < 5; n++) begin
      step();
      chk("t5_no_dispatch", cif.core_start, 2'b00);
      chk("t5_idle", busy, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
